key_event_seq: RTL and testbench
================================

KEY_EVENT_SEQ -- requirements
Module: key_event_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200_000, meaning clk cycles allowed between prefix byte and its follow-up byte.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_byte  input  8  byte from PS/2 receiver, valid only when rx_valid=1.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe, one byte per strobe, no backpressure.
REQ-006 SHALL have port keycode  output  16  last completed event: [15:8]=8'hF0 break, 8'hE0 extended make, 8'h00 plain make; [7:0]=key code.
REQ-007 SHALL have port key_valid  output  1  one-cycle pulse in the cycle keycode updates.
REQ-008 SHALL have port key_ext  output  1  event carried E0 prefix; updates with keycode.
REQ-009 SHALL have port seq_err  output  1  one-cycle pulse on timeout or error byte.

Function
REQ-010 SHALL implement FSM states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (inside E1 pause sequence).
REQ-011 IDLE: byte E0 -> EXT; F0 -> BRK; E1 -> SKIP, skip counter=7; FA, AA, EE, FE -> discarded, stay IDLE; 00 or FF -> seq_err pulse, stay IDLE; any other byte -> make event, stay IDLE.
REQ-012 EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> extended make event, -> IDLE.
REQ-013 BRK: any byte except E0/F0/E1 -> break event, -> IDLE; E0/F0/E1 -> seq_err, -> IDLE, byte discarded.
REQ-014 EXT_BRK: any byte except E0/F0/E1 -> extended break event, -> IDLE; E0/F0/E1 -> seq_err, -> IDLE.
REQ-015 SKIP: each rx_valid decrements skip counter, no event output; -> IDLE on the strobe that brings the counter to 0 (8 bytes total including E1).
REQ-016 Event: registered, keycode/key_ext/key_valid take effect the cycle after the completing rx_valid (latency 1 clk).
REQ-017 Make event: keycode={8'h00,byte}, key_ext=0; extended make: {8'hE0,byte}, key_ext=1.
REQ-018 Break event: keycode={8'hF0,byte}, key_ext=0; extended break: {8'hF0,byte}, key_ext=1.
REQ-019 keycode and key_ext SHALL hold their value between events; key_valid and seq_err SHALL be 0 except on their pulse cycle.
REQ-020 Timeout counter SHALL clear on every rx_valid and count while state is not IDLE; counter at TIMEOUT-1 with no rx_valid -> seq_err pulse, -> IDLE.
REQ-021 rx_valid in the same cycle as timeout expiry: byte SHALL be processed normally, no timeout.
REQ-022 Counter width SHALL be $clog2(TIMEOUT+1); counter SHALL saturate, never wrap.
REQ-023 rx_valid while not in IDLE and no error SHALL never be dropped; one byte consumed per strobe, back-to-back strobes supported.

Reset
REQ-024 rst SHALL force state IDLE, keycode=16'h0000, key_ext=0, key_valid=0, seq_err=0, timeout and skip counters=0.
REQ-025 rst SHALL override rx_valid in the same cycle; a partial sequence in progress SHALL be abandoned without event or seq_err.

Structure
REQ-026 Package kbd_pkg SHALL hold scan-code constants (LEFT 1C, RIGHT 23, UP 1D, ENTER 5A, STOP F0, EXT E0, PAUSE E1, ACK FA, BAT AA, ECHO EE, RESEND FE, ERR0 00, ERRF FF) and the FSM state enum.
REQ-027 Timeout counter SHALL be sub-module key_timer (clk, rst, clear, enable, expired), parameterised by TIMEOUT.
REQ-028 FSM SHALL be two-process: registered state, combinational next state; all outputs registered.

Verification
REQ-029 Bytes 1C -> key_valid one cycle later, keycode=16'h001C, key_ext=0.
REQ-030 Bytes F0,23 back-to-back -> one key_valid, keycode=16'hF023; no event after F0 alone.
REQ-031 Bytes E0,F0,5A -> keycode=16'hF05A, key_ext=1; E0,75 -> 16'hE075, key_ext=1.
REQ-032 F0 then no byte for TIMEOUT cycles (TIMEOUT=16 in bench) -> seq_err pulse, state IDLE; next byte 1D -> keycode=16'h001D.
REQ-033 E1,14,77,E1,F0,14,F0,77 then 1C -> no event for first 8 bytes, then keycode=16'h001C.
REQ-034 F0 then rst pulse then 1D -> keycode=16'h001D, no seq_err, keycode 0000 during reset.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared PS/2 scan-code constants and the sequencer state type.
package kbd_pkg;

    // Ordinary key codes used by the front-panel firmware
    localparam logic [7:0] SC_LEFT   = 8'h1C;
    localparam logic [7:0] SC_RIGHT  = 8'h23;
    localparam logic [7:0] SC_UP     = 8'h1D;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    // Prefix bytes that start a multi-byte event
    localparam logic [7:0] SC_STOP   = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;

    // Keyboard status replies that never form a key event
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;

    // Keyboard buffer-overrun / error indications
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERRF   = 8'hFF;

    // The pause key sends E1 followed by seven more bytes
    localparam logic [2:0] PAUSE_TAIL_BYTES = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } seq_state_t;

    // True for any byte that can only open a sequence, never finish one
    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_EXT) || (b == SC_STOP) || (b == SC_PAUSE);
    endfunction

endpackage

// File: rtl/key_timer.sv
// Inter-byte watchdog: counts idle cycles inside a multi-byte sequence.
module key_timer #(
    parameter int TIMEOUT = 200_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
    localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Counter restarts on every byte and saturates at LIMIT so it can never wrap back to a small value
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + W'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/key_event_seq.sv
// Turns the raw PS/2 byte stream into make/break key events with prefix handling.
module key_event_seq
    import kbd_pkg::*;
#(
    parameter int TIMEOUT = 200_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [15:0] keycode,
    output logic        key_valid,
    output logic        key_ext,
    output logic        seq_err
);

    seq_state_t state, state_next;
    logic [2:0] skip_cnt, skip_next;
    logic       ev_valid;
    logic [7:0] ev_hi;
    logic       ev_ext;
    logic       ev_err;
    logic       timer_expired;

    // Watchdog only runs while a sequence is open; any byte restarts it
    key_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid || (state == ST_IDLE)),
        .enable  (state != ST_IDLE),
        .expired (timer_expired)
    );

    // Next-state and event decode; a byte arriving on the expiry cycle wins over the timeout
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        ev_valid   = 1'b0;
        ev_hi      = 8'h00;
        ev_ext     = 1'b0;
        ev_err     = 1'b0;
        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_byte == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (rx_byte == SC_STOP) begin
                        state_next = ST_BRK;
                    end else if (rx_byte == SC_PAUSE) begin
                        state_next = ST_SKIP;
                        skip_next  = PAUSE_TAIL_BYTES;
                    end else if ((rx_byte == SC_ACK) || (rx_byte == SC_BAT) ||
                                 (rx_byte == SC_ECHO) || (rx_byte == SC_RESEND)) begin
                        state_next = ST_IDLE;
                    end else if ((rx_byte == SC_ERR0) || (rx_byte == SC_ERRF)) begin
                        ev_err = 1'b1;
                    end else begin
                        ev_valid = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_byte == SC_STOP) begin
                        state_next = ST_EXT_BRK;
                    end else if (rx_byte == SC_EXT) begin
                        state_next = ST_EXT;
                    end else begin
                        ev_valid   = 1'b1;
                        ev_hi      = SC_EXT;
                        ev_ext     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_next = ST_IDLE;
                    if (is_prefix(rx_byte)) begin
                        ev_err = 1'b1;
                    end else begin
                        ev_valid = 1'b1;
                        ev_hi    = SC_STOP;
                    end
                end
                ST_EXT_BRK: begin
                    state_next = ST_IDLE;
                    if (is_prefix(rx_byte)) begin
                        ev_err = 1'b1;
                    end else begin
                        ev_valid = 1'b1;
                        ev_hi    = SC_STOP;
                        ev_ext   = 1'b1;
                    end
                end
                ST_SKIP: begin
                    if (skip_cnt <= 3'd1) begin
                        skip_next  = 3'd0;
                        state_next = ST_IDLE;
                    end else begin
                        skip_next = skip_cnt - 3'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    skip_next  = 3'd0;
                end
            endcase
        end else if (timer_expired) begin
            ev_err     = 1'b1;
            state_next = ST_IDLE;
            skip_next  = 3'd0;
        end
    end

    // State and pause-skip counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
        end
    end

    // Registered outputs: keycode/key_ext hold between events, the strobes last one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            keycode   <= 16'h0000;
            key_ext   <= 1'b0;
            key_valid <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            key_valid <= ev_valid;
            seq_err   <= ev_err;
            if (ev_valid) begin
                keycode <= {ev_hi, rx_byte};
                key_ext <= ev_ext;
            end
        end
    end

endmodule

// File: tb/tb_key_event_seq.sv
// Self-checking bench for key_event_seq: vector table plus hand-written timing/reset cases.
module tb_key_event_seq;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [15:0] keycode;
    logic        key_valid;
    logic        key_ext;
    logic        seq_err;

    key_event_seq #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .keycode   (keycode),
        .key_valid (key_valid),
        .key_ext   (key_ext),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic        ev;
        logic [15:0] code;
        logic        ext;
        logic        err;
    } vec_t;

    typedef struct {
        logic        ev;
        logic        err;
        logic [15:0] code;
        logic        ext;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one byte strobe starting at a negedge; the expected result goes into the scoreboard first
    task automatic applyStimulus(input logic [7:0] b, input logic ev, input logic [15:0] code,
                                 input logic ext, input logic err);
        exp_t e;
        if (ev || err) begin
            e.ev = ev; e.err = err; e.code = code; e.ext = ext;
            expQ.push_back(e);
        end
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 10; i++) begin
            if (expQ.size() == 0) break;
            @(negedge clk);
        end
        checkOutput(name, 16'(expQ.size()), 16'd0);
    endtask

    // Scoreboard monitor: every output pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && (key_valid === 1'b1 || seq_err === 1'b1)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected pulse: got key_valid=%b seq_err=%b keycode=%h expected none",
                         key_valid, seq_err, keycode);
            end else begin
                e = expQ.pop_front();
                checkOutput("key_valid", {15'd0, key_valid}, {15'd0, e.ev});
                checkOutput("seq_err", {15'd0, seq_err}, {15'd0, e.err});
                if (e.ev) begin
                    checkOutput("keycode", keycode, e.code);
                    checkOutput("key_ext", {15'd0, key_ext}, {15'd0, e.ext});
                end
            end
        end
    end

    vec_t vecs[$];

    initial begin
        int lat;
        vecs = '{
            '{8'h1C, 1'b1, 16'h001C, 1'b0, 1'b0},
            '{8'hF0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'h23, 1'b1, 16'hF023, 1'b0, 1'b0},
            '{8'hE0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'hF0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'h5A, 1'b1, 16'hF05A, 1'b1, 1'b0},
            '{8'hE0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'h75, 1'b1, 16'hE075, 1'b1, 1'b0},
            '{8'hFA, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'hAA, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'hEE, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'hFE, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'h00, 1'b0, 16'h0000, 1'b0, 1'b1},
            '{8'hFF, 1'b0, 16'h0000, 1'b0, 1'b1},
            '{8'hE1, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'h14, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'h77, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'hE1, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'hF0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'h14, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'hF0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'h77, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'h1C, 1'b1, 16'h001C, 1'b0, 1'b0},
            '{8'hE0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'hE0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'h1D, 1'b1, 16'hE01D, 1'b1, 1'b0},
            '{8'hF0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'hE0, 1'b0, 16'h0000, 1'b0, 1'b1},
            '{8'hE0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'hF0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'hF0, 1'b0, 16'h0000, 1'b0, 1'b1},
            '{8'hF0, 1'b0, 16'h0000, 1'b0, 1'b0},
            '{8'h5A, 1'b1, 16'hF05A, 1'b0, 1'b0}
        };

        rst      = 1'b1;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset keycode", keycode, 16'h0000);
        checkOutput("reset key_ext", {15'd0, key_ext}, 16'd0);
        checkOutput("reset key_valid", {15'd0, key_valid}, 16'd0);
        checkOutput("reset seq_err", {15'd0, seq_err}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] vector table, back-to-back strobes");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].b, vecs[i].ev, vecs[i].code, vecs[i].ext, vecs[i].err);
        end
        waitDrain("table drained");
        repeat (3) @(negedge clk);
        checkOutput("hold keycode", keycode, 16'hF05A);
        checkOutput("hold key_ext", {15'd0, key_ext}, 16'd0);
        checkOutput("hold key_valid", {15'd0, key_valid}, 16'd0);

        $display("[TB] timeout after lone F0");
        applyStimulus(8'hF0, 1'b0, 16'h0, 1'b0, 1'b0);
        expQ.push_back('{ev: 1'b0, err: 1'b1, code: 16'h0, ext: 1'b0});
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (seq_err === 1'b1) begin
                lat = i;
                break;
            end
        end
        checkOutput("timeout latency", 16'(lat), 16'(TIMEOUT));
        applyStimulus(8'h1D, 1'b1, 16'h001D, 1'b0, 1'b0);
        waitDrain("timeout drained");

        $display("[TB] byte on the expiry cycle");
        applyStimulus(8'hF0, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (TIMEOUT - 1) @(negedge clk);
        applyStimulus(8'h23, 1'b1, 16'hF023, 1'b0, 1'b0);
        repeat (TIMEOUT + 4) @(negedge clk);
        waitDrain("expiry drained");

        $display("[TB] reset abandons F0");
        applyStimulus(8'hF0, 1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid reset keycode", keycode, 16'h0000);
        checkOutput("mid reset seq_err", {15'd0, seq_err}, 16'd0);
        rst = 1'b0;
        repeat (TIMEOUT + 4) @(negedge clk);
        applyStimulus(8'h1D, 1'b1, 16'h001D, 1'b0, 1'b0);
        waitDrain("reset drained");

        $display("[TB] reset overrides rx_valid");
        rst      = 1'b1;
        rx_byte  = 8'h1C;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        checkOutput("reset+valid keycode", keycode, 16'h0000);
        checkOutput("reset+valid key_valid", {15'd0, key_valid}, 16'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(8'h5A, 1'b1, 16'h005A, 1'b0, 1'b0);
        waitDrain("final drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case something hangs
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
